pe_mac_lanes: RTL

Parametrised multi-lane multiply-accumulate processing element for the CNN datapath; successor to the single-lane 8-bit PE. It accepts LANES signed IFM/weight pairs per beat, reduces them into a wide accumulator over a runtime-programmable window of k_len beats, then requantises the sum (round, shift, saturate) to OUT_W bits. The block sits between the IFM/weight line buffers and the OFM writeback, with valid/ready handshakes on both sides.

---
 rtl/pe_mac_lanes_pkg.sv | 34 +++
 rtl/pe_mac_lanes_if.sv | 28 ++
 rtl/pe_mac_lanes_dot.sv | 29 ++
 rtl/pe_mac_lanes.sv | 91 +++++++++
 4 files changed

// File: rtl/pe_mac_lanes_pkg.sv
// Shared widths, FSM state type and the requantisation helper for the PE family.
package pe_pkg;

   localparam int DATA_W = 8;
   localparam int ACC_W  = 24;
   localparam int OUT_W  = 8;
   localparam int CNT_W  = 10;

   typedef enum logic {IDLE, ACC} pe_state_t;

   localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

   // Round half-up, arithmetic shift, saturate; one extra bit keeps the rounding add from wrapping.
   function automatic logic signed [OUT_W-1:0] requant(input logic signed [ACC_W-1:0] fin,
                                                      input logic [4:0]               sh);
      logic signed [ACC_W:0] ext;
      logic signed [ACC_W:0] half;
      logic signed [ACC_W:0] shd;
      logic signed [OUT_W-1:0] res;
      ext  = {fin[ACC_W-1], fin};
      half = (sh == 5'd0) ? '0 : ((ACC_W+1)'(1) << (sh - 5'd1));
      shd  = (ext + half) >>> sh;
      if (shd > (ACC_W+1)'(OUT_MAX)) begin
         res = OUT_MAX;
      end else if (shd < (ACC_W+1)'(OUT_MIN)) begin
         res = OUT_MIN;
      end else begin
         res = shd[OUT_W-1:0];
      end
      return res;
   endfunction

endpackage

// File: rtl/pe_mac_lanes_if.sv
// Beat input and result output handshake bundle of the multi-lane MAC processing element.
interface pe_mac_lanes_if #(
   parameter int LANES  = 4,
   parameter int DATA_W = pe_pkg::DATA_W,
   parameter int OUT_W  = pe_pkg::OUT_W,
   parameter int CNT_W  = pe_pkg::CNT_W
);
   logic                    in_valid;
   logic                    in_ready;
   logic [LANES*DATA_W-1:0] ifm;
   logic [LANES*DATA_W-1:0] weight;
   logic [CNT_W-1:0]        k_len;
   logic [4:0]              shift;
   logic                    out_valid;
   logic                    out_ready;
   logic [OUT_W-1:0]        ofm;
   logic                    busy;

   modport master (
      output in_valid, ifm, weight, k_len, shift, out_ready,
      input  in_ready, out_valid, ofm, busy
   );

   modport slave (
      input  in_valid, ifm, weight, k_len, shift, out_ready,
      output in_ready, out_valid, ofm, busy
   );
endinterface

// File: rtl/pe_mac_lanes_dot.sv
// Combinational LANES-wide signed multiply and reduction into one accumulator-width beat sum.
module pe_lane_dot #(
   parameter int LANES  = 4,
   parameter int DATA_W = pe_pkg::DATA_W,
   parameter int ACC_W  = pe_pkg::ACC_W
) (
   input  logic [LANES*DATA_W-1:0] ifm,
   input  logic [LANES*DATA_W-1:0] weight,
   output logic signed [ACC_W-1:0] beat_sum
);

   logic signed [DATA_W-1:0]   a;
   logic signed [DATA_W-1:0]   b;
   logic signed [2*DATA_W-1:0] prod;

   always_comb begin
      beat_sum = '0;
      a        = '0;
      b        = '0;
      prod     = '0;
      for (int i = 0; i < LANES; i++) begin
         a        = ifm[i*DATA_W +: DATA_W];
         b        = weight[i*DATA_W +: DATA_W];
         prod     = a * b;
         beat_sum = beat_sum + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
      end
   end

endmodule

// File: rtl/pe_mac_lanes.sv
// Multi-lane MAC PE: accumulates k_len beats, then requantises to OUT_W bits.
// Define PE_RELU_EN to clamp negative results to zero before they reach ofm.
module pe_mac_lanes #(
   parameter int LANES  = 4,
   parameter int DATA_W = pe_pkg::DATA_W,
   parameter int ACC_W  = pe_pkg::ACC_W,
   parameter int OUT_W  = pe_pkg::OUT_W,
   parameter int CNT_W  = pe_pkg::CNT_W
) (
   input logic          clk,
   input logic          reset_n,
   pe_mac_lanes_if.slave bus
);
   import pe_pkg::*;

   pe_state_t               state;
   logic [CNT_W-1:0]        count;
   logic [CNT_W-1:0]        k_len_q;
   logic [CNT_W-1:0]        eff_k;
   logic [4:0]              shift_q;
   logic [4:0]              cur_shift;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] beat_sum;
   logic signed [ACC_W-1:0] fin;
   logic signed [OUT_W-1:0] sat;
   logic signed [OUT_W-1:0] res;
   logic                    final_beat;
   logic                    accept;
   logic                    out_valid_q;
   logic [OUT_W-1:0]        ofm_q;

   pe_lane_dot #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W)) u_dot (
      .ifm      (bus.ifm),
      .weight   (bus.weight),
      .beat_sum (beat_sum)
   );

   // In IDLE the live k_len/shift apply, since the first beat may also close the window.
   always_comb begin
      eff_k      = (bus.k_len == '0) ? CNT_W'(1) : bus.k_len;
      final_beat = (state == IDLE) ? (eff_k == CNT_W'(1)) : (count == k_len_q - CNT_W'(1));
      cur_shift  = (state == IDLE) ? bus.shift : shift_q;
      fin        = acc + beat_sum;
      sat        = requant(fin, cur_shift);
`ifdef PE_RELU_EN
      res        = sat[OUT_W-1] ? '0 : sat;
`else
      res        = sat;
`endif
   end

   assign bus.in_ready  = !out_valid_q || bus.out_ready || !final_beat;
   assign accept        = bus.in_valid && bus.in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.ofm       = ofm_q;
   assign bus.busy      = (count != '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         count       <= '0;
         k_len_q     <= CNT_W'(1);
         shift_q     <= '0;
         acc         <= '0;
         out_valid_q <= 1'b0;
         ofm_q       <= '0;
      end else begin
         if (bus.out_valid && bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
         if (accept) begin
            if (state == IDLE) begin
               k_len_q <= eff_k;
               shift_q <= bus.shift;
            end
            if (final_beat) begin
               acc         <= '0;
               count       <= '0;
               state       <= IDLE;
               ofm_q       <= res;
               out_valid_q <= 1'b1;
            end else begin
               acc   <= fin;
               count <= count + CNT_W'(1);
               state <= ACC;
            end
         end
      end
   end

endmodule
